// File: rtl/sort_sched8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_sched8_pkg
// Description : Shared state encoding and comparator bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package sort_sched8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CMP_GT = 2;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 0;

endpackage
`default_nettype wire

// File: rtl/sort_sched8_cmp.sv
`default_nettype none
// ============================================================================
// Module      : DataCompare8
// Description : 8-bit magnitude comparator, one-hot {A>B, A==B, A<B}.
// Revision    : 1.0 - initial release
// ============================================================================
module DataCompare8
  import sort_sched8_pkg::*;
(
  input  logic [7:0] iA,
  input  logic [7:0] iB,
  output logic [2:0] oCmp
);

  always_comb begin
    oCmp         = '0;
    oCmp[CMP_GT] = (iA > iB);
    oCmp[CMP_EQ] = (iA == iB);
    oCmp[CMP_LT] = (iA < iB);
  end

endmodule
`default_nettype wire

// File: rtl/sort_sched8.sv
`default_nettype none
// ============================================================================
// Module      : sort_sched8
// Description : In-place bubble-sort scheduler, one shared compare per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_sched8
  import sort_sched8_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iWrEn,
  input  logic [AW-1:0] iWrAddr,
  input  logic [7:0]    iWrData,
  input  logic          iStart,
  input  logic          iDescend,
  input  logic [AW-1:0] iRdAddr,
  output logic [7:0]    oRdData,
  output logic          oBusy,
  output logic          oDone,
  output logic [AW:0]   oPassCnt
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  state_e        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] idx_q;
  logic [AW-1:0] pass_end_q;
  logic          swapped_q;
  logic          descend_q;
  logic          busy_q;
  logic          done_q;
  logic [AW:0]   pass_cnt_q;

  logic [AW-1:0] w_idx_nxt;
  logic [AW-1:0] w_pass_last;
  logic [7:0]    w_a;
  logic [7:0]    w_b;
  logic [2:0]    w_cmp;
  logic          w_ooo;
  logic          w_swap_seen;
  logic          w_wr_ok;
  logic          w_rd_ok;

  assign w_idx_nxt   = idx_q + 1'b1;
  assign w_pass_last = pass_end_q - 1'b1;
  assign w_a         = mem_q[idx_q];
  assign w_b         = mem_q[w_idx_nxt];

  DataCompare8 u_cmp (
    .iA   (w_a),
    .iB   (w_b),
    .oCmp (w_cmp)
  );

  // Equal operands never swap, which keeps the sort stable.
  assign w_ooo       = !w_cmp[CMP_EQ] && (descend_q ? w_cmp[CMP_LT] : w_cmp[CMP_GT]);
  assign w_swap_seen = swapped_q | w_ooo;

  assign w_wr_ok  = ({1'b0, iWrAddr} < DEPTH_W);
  assign w_rd_ok  = ({1'b0, iRdAddr} < DEPTH_W);
  assign oRdData  = w_rd_ok ? mem_q[iRdAddr] : 8'h00;
  assign oBusy    = busy_q;
  assign oDone    = done_q;
  assign oPassCnt = pass_cnt_q;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      idx_q      <= '0;
      pass_end_q <= LAST_IDX;
      swapped_q  <= 1'b0;
      descend_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iWrEn && w_wr_ok) mem_q[iWrAddr] <= iWrData;
          if (iStart) begin
            state_q    <= ST_SORT;
            busy_q     <= 1'b1;
            descend_q  <= iDescend;
            idx_q      <= '0;
            pass_end_q <= LAST_IDX;
            swapped_q  <= 1'b0;
            pass_cnt_q <= (AW + 1)'(1);
          end
        end
        ST_SORT: begin
          if (w_ooo) begin
            mem_q[idx_q]     <= w_b;
            mem_q[w_idx_nxt] <= w_a;
            swapped_q        <= 1'b1;
          end
          if (idx_q != w_pass_last) begin
            idx_q <= w_idx_nxt;
          end else if (!w_swap_seen || (pass_end_q == AW'(1))) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pass_end_q <= w_pass_last;
            idx_q      <= '0;
            swapped_q  <= 1'b0;
            pass_cnt_q <= pass_cnt_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_sched8.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_sched8
// Description : Self-checking bench for sort_sched8 against a bubble-sort model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_sched8;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef logic [7:0] vec_t [DEPTH];

  logic          iClk     = 1'b0;
  logic          iRst_n   = 1'b0;
  logic          iWrEn    = 1'b0;
  logic [AW-1:0] iWrAddr  = '0;
  logic [7:0]    iWrData  = '0;
  logic          iStart   = 1'b0;
  logic          iDescend = 1'b0;
  logic [AW-1:0] iRdAddr  = '0;
  logic [7:0]    oRdData;
  logic          oBusy;
  logic          oDone;
  logic [AW:0]   oPassCnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 iClk = ~iClk;

  sort_sched8 #(.DEPTH(DEPTH)) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iWrEn    (iWrEn),
    .iWrAddr  (iWrAddr),
    .iWrData  (iWrData),
    .iStart   (iStart),
    .iDescend (iDescend),
    .iRdAddr  (iRdAddr),
    .oRdData  (oRdData),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oPassCnt (oPassCnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_res [DEPTH];
  int         m_left  = 0;
  int         m_pass  = 0;
  bit         m_done  = 1'b0;
  int         m_lat;
  int         m_npass;

  // Plain bubble sort with early exit; counts compares and passes.
  function automatic void model_sort(input bit desc);
    logic [7:0] t;
    bit sw;
    for (int i = 0; i < DEPTH; i++) m_res[i] = m_mem[i];
    m_lat   = 0;
    m_npass = 0;
    for (int e = DEPTH - 1; e >= 1; e--) begin
      sw = 1'b0;
      m_npass++;
      for (int i = 0; i < e; i++) begin
        m_lat++;
        if (desc ? (m_res[i] < m_res[i+1]) : (m_res[i] > m_res[i+1])) begin
          t = m_res[i]; m_res[i] = m_res[i+1]; m_res[i+1] = t;
          sw = 1'b1;
        end
      end
      if (!sw) break;
    end
  endfunction

  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_left = 0;
      m_pass = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = m_res[i];
      end
    end else begin
      if (iWrEn) m_mem[iWrAddr] = iWrData;
      if (iStart) begin
        model_sort(iDescend);
        m_left = m_lat;
        m_pass = m_npass;
      end
    end
  end

  // Per-cycle comparison of DUT against the model.
  always @(negedge iClk) begin
    if (chk_en) begin
      chk("busy", {31'd0, oBusy}, {31'd0, (m_left > 0)});
      chk("done", {31'd0, oDone}, {31'd0, m_done});
      if (m_left == 0) begin
        chk("passcnt", {28'd0, oPassCnt}, m_pass);
        chk("rddata", {24'd0, oRdData}, {24'd0, m_mem[iRdAddr]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load(input vec_t v);
    for (int i = 0; i < DEPTH; i++) begin
      iWrEn   = 1'b1;
      iWrAddr = AW'(i);
      iWrData = v[i];
      @(posedge iClk); #1;
    end
    iWrEn = 1'b0;
  endtask

  task automatic readback(input string name, input vec_t exp);
    for (int i = 0; i < DEPTH; i++) begin
      iRdAddr = AW'(i);
      #2;
      chk(name, {24'd0, oRdData}, {24'd0, exp[i]});
      @(posedge iClk); #1;
    end
  endtask

  task automatic run(input bit desc, input bit disturb, output int lat);
    iStart   = 1'b1;
    iDescend = desc;
    @(posedge iClk); #1;
    iStart = 1'b0;
    lat    = 0;
    while (oDone !== 1'b1 && lat < 100) begin
      if (disturb && lat == 2) begin
        iWrEn = 1'b1; iWrAddr = '0; iWrData = 8'hFF; iStart = 1'b1;
      end
      if (disturb && lat == 5) begin
        iWrEn = 1'b0; iStart = 1'b0;
      end
      @(posedge iClk); #1;
      lat++;
    end
    iWrEn  = 1'b0;
    iStart = 1'b0;
    chk("done_seen", {31'd0, oDone}, 32'd1);
    chk("busy_at_done", {31'd0, oBusy}, 32'd0);
    @(posedge iClk); #1;
    chk("done_pulse_end", {31'd0, oDone}, 32'd0);
  endtask

  vec_t v_mixed, v_mixed_s, v_up, v_down, v_eq, v_one8, v_eight1, v_zero;
  int   lat;

  initial begin
    v_mixed   = '{8'h80, 8'h70, 8'h30, 8'h10, 8'h70, 8'h00, 8'h3C, 8'h11};
    v_mixed_s = '{8'h00, 8'h10, 8'h11, 8'h30, 8'h3C, 8'h70, 8'h70, 8'h80};
    v_up      = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    v_down    = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    v_eq      = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    v_one8    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    v_eight1  = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    v_zero    = '{default: 8'h00};

    repeat (2) @(posedge iClk);
    #1;
    chk("rst_busy", {31'd0, oBusy}, 32'd0);
    chk("rst_done", {31'd0, oDone}, 32'd0);
    chk("rst_passcnt", {28'd0, oPassCnt}, 32'd0);
    chk("rst_rd", {24'd0, oRdData}, 32'd0);
    iRst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge iClk); #1;

    // Mixed data ascending: 6 passes, 7+6+5+4+3+2 = 27 cycles.
    load(v_mixed);
    run(1'b0, 1'b0, lat);
    chk("mixed_lat", lat, 32'd27);
    chk("mixed_pass", {28'd0, oPassCnt}, 32'd6);
    readback("mixed_data", v_mixed_s);

    load(v_up);
    run(1'b0, 1'b0, lat);
    chk("best_lat", lat, 32'd7);
    chk("best_pass", {28'd0, oPassCnt}, 32'd1);
    readback("best_data", v_up);

    load(v_down);
    run(1'b0, 1'b0, lat);
    chk("worst_lat", lat, 32'd28);
    chk("worst_pass", {28'd0, oPassCnt}, 32'd7);
    readback("worst_data", v_up);

    load(v_eq);
    run(1'b1, 1'b0, lat);
    chk("equal_lat", lat, 32'd7);
    chk("equal_pass", {28'd0, oPassCnt}, 32'd1);
    readback("equal_data", v_eq);

    load(v_one8);
    run(1'b1, 1'b0, lat);
    chk("desc_lat", lat, 32'd28);
    chk("desc_pass", {28'd0, oPassCnt}, 32'd7);
    readback("desc_data", v_eight1);

    // Writes and starts while busy must be ignored.
    load(v_mixed);
    run(1'b0, 1'b1, lat);
    chk("busy_prot_lat", lat, 32'd27);
    chk("busy_prot_pass", {28'd0, oPassCnt}, 32'd6);
    readback("busy_prot_data", v_mixed_s);

    // Asynchronous reset in cycle 5 of a worst-case sort.
    load(v_down);
    iStart = 1'b1; iDescend = 1'b0;
    @(posedge iClk); #1;
    iStart = 1'b0;
    repeat (4) @(posedge iClk);
    #1;
    chk("midsort_busy", {31'd0, oBusy}, 32'd1);
    iRst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, oBusy}, 32'd0);
    chk("arst_done", {31'd0, oDone}, 32'd0);
    chk("arst_passcnt", {28'd0, oPassCnt}, 32'd0);
    readback("arst_data", v_zero);
    iRst_n = 1'b1;
    @(posedge iClk); #1;

    load(v_mixed);
    run(1'b0, 1'b0, lat);
    chk("post_rst_lat", lat, 32'd27);
    readback("post_rst_data", v_mixed_s);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_sched8.md
Name: sort_sched8

Overview:
- In-place bubble-sort scheduler for a DEPTH-entry buffer of 8-bit values. It time-shares one instance of the 8-bit magnitude comparator, issuing one compare per clock.
- Sits between a host that loads and reads the buffer and the comparator datapath. It sequences every compare and swap, and signals completion with a one-cycle done pulse.

Parameters:
- DEPTH, 8, number of buffer entries; legal range 2..16. Index width AW = clog2(DEPTH).

Ports:
- iClk  input  1  system clock; all state changes on its rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iWrEn  input  1  write strobe; honoured only in IDLE.
- iWrAddr  input  AW  write index.
- iWrData  input  8  write data.
- iStart  input  1  start sort; sampled only in IDLE.
- iDescend  input  1  sort order: 0 = ascending, 1 = descending. Latched when iStart is accepted.
- iRdAddr  input  AW  read index.
- oRdData  output  8  combinational read of entry iRdAddr; valid in every state, shows in-progress contents during SORT.
- oBusy  output  1  high while in SORT.
- oDone  output  1  one-cycle pulse on sort completion.
- oPassCnt  output  AW+1  passes executed by the last sort; holds until the next accepted start.

Behaviour:
- Reset (async, iRst_n=0):
  - state=IDLE; all buffer entries=0.
  - oBusy=0, oDone=0, oPassCnt=0.
  - Internal idx=0, pass_end=DEPTH-1, swapped=0.
  - Reset mid-sort aborts immediately; the partially sorted contents are lost (cleared).
- Comparator contract:
  - A = mem[idx], B = mem[idx+1].
  - Output is one-hot 3 bits {A>B, A==B, A<B}.
  - Out-of-order means A>B when ascending, A<B when descending.
  - Equal values are never swapped, so the sort is stable.
- IDLE:
  - iWrEn=1 writes iWrData to mem[iWrAddr] at the clock edge.
  - iStart=1 moves to SORT, latches iDescend, and sets idx=0, pass_end=DEPTH-1, swapped=0, oPassCnt=1.
  - iWrEn and iStart together in the same cycle: the write is performed and the sort starts on the updated contents. Required ordering: the write is committed before the first compare.
- SORT, one compare per cycle:
  - If out-of-order: swap mem[idx] and mem[idx+1] at the edge and set swapped=1.
  - If idx != pass_end-1: idx <= idx+1.
  - Else (end of pass):
    - If no swap occurred this pass (including the current compare) or pass_end==1: go to DONE.
    - Otherwise: pass_end <= pass_end-1, idx=0, swapped=0, oPassCnt <= oPassCnt+1.
- DONE: oDone=1 and oBusy=0 for exactly one cycle, then return to IDLE.
- In SORT and DONE, iWrEn and iStart are ignored; no queuing, no error flag.
- Latency, counted from the edge that accepts iStart to oDone high:
  - Already-sorted input: DEPTH-1 cycles, 1 pass.
  - Fully reversed input: DEPTH*(DEPTH-1)/2 cycles, DEPTH-1 passes.
  - DEPTH=8: 7 cycles / 1 pass best case; 28 cycles / 7 passes worst case.
- Index arithmetic is unsigned. idx never exceeds pass_end-1, so the buffer is never read out of range. Out-of-range iWrAddr/iRdAddr (non-power-of-2 DEPTH) are ignored on write and return 0 on read.

Decomposition:
- Shared package holds:
  - The state encoding (IDLE, SORT, DONE).
  - Comparator output bit positions CMP_GT=2, CMP_EQ=1, CMP_LT=0.
- The existing 8-bit comparator DataCompare8 is instantiated once as the sub-module. No other sub-module; the buffer is a flop array inside sort_sched8.

Test Plan (DEPTH=8):
- Ascending sort, mixed data:
  - Stimulus: load {0x80,0x70,0x30,0x10,0x70,0x00,0x3C,0x11}, iStart with iDescend=0.
  - Required: read-back {0x00,0x10,0x11,0x30,0x3C,0x70,0x70,0x80}; oDone exactly one cycle; oBusy low afterwards.
- Best case:
  - Stimulus: load 0x00..0x07 ascending, start ascending.
  - Required: oDone 7 cycles after the start edge; oPassCnt=1; contents unchanged.
- Worst case:
  - Stimulus: load 0x07..0x00 (reversed), start ascending.
  - Required: oDone at cycle 28; oPassCnt=7; result 0x00..0x07.
- Descending and equal values:
  - Stimulus: all entries 0x3C, start descending.
  - Required: zero swaps, oPassCnt=1, done at cycle 7.
  - Then load {0x01,0x02,...,0x08}, start descending.
  - Required: result 0x08..0x01.
- Busy protection:
  - Stimulus: during SORT, assert iWrEn (addr 0, data 0xFF) and iStart.
  - Required: no effect; result matches the undisturbed run; only one oDone pulse.
- Reset mid-sort:
  - Stimulus: drop iRst_n at cycle 5 of a worst-case sort.
  - Required: oBusy and oDone go 0 immediately (asynchronously); all entries read 0x00; oPassCnt=0.
  - Then a fresh load and start completes normally.
